hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline hazard controller that pairs with the EX-stage forwarding logic.
- Forwarding supplies operands once they exist. This block detects hazards that forwarding cannot cover and stalls or flushes the front end: load-use, and branch-in-ID operand dependencies.
- Sits beside the IF/ID and ID/EX pipeline registers and drives the PC, IF/ID and ID/EX write/flush controls.
- Keeps consecutive-stall watchdog state and saturating performance counters.

Parameters:
- CNT_W, 16, width of the StallCycles and FlushCount performance counters
- MAX_STALL, 4, consecutive stall cycles that trigger the deadlock halt; legal range 3..15

Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- ID_Rs  in  5  source register 1 of the instruction in ID
- ID_Rt  in  5  source register 2 of the instruction in ID
- ID_UsesRt  in  1  the ID instruction reads Rt as an operand
- ID_Branch  in  1  the ID instruction is a branch resolved in ID
- ID_BranchTaken  in  1  branch comparison result; meaningful only when ID_Branch=1
- EX_RegWriteAddress  in  5  destination register in EX
- EX_RegWrite  in  2  register-write class in EX; nonzero means a write
- EX_MemRead  in  1  the EX instruction is a load
- MEM_RegWriteAddress  in  5  destination register in MEM
- MEM_MemRead  in  1  the MEM instruction is a load
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register write enable
- IF_ID_Flush  out  1  zero the IF/ID register (taken-branch squash)
- ID_EX_Bubble  out  1  insert a NOP into ID/EX
- Deadlock  out  1  sticky watchdog error
- StallCycles  out  CNT_W  saturating count of stall cycles
- FlushCount  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Match rule for a register address A: A != 0, and (A == ID_Rs, or ID_UsesRt=1 and A == ID_Rt).
- LU = EX_MemRead and match(EX_RegWriteAddress).
- BRE = ID_Branch and EX_RegWrite != 0 and match(EX_RegWriteAddress).
- BRM = ID_Branch and MEM_MemRead and match(MEM_RegWriteAddress).
- Stall = LU or BRE or BRM. All are combinational from the current inputs, so a branch after a load stalls 2 cycles and a branch after an ALU op stalls 1 cycle.
- Outputs are combinational and prioritised in this order:
  - Rst=1 or state HALT: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
  - Stall=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. The branch decision is ignored while stalled.
  - ID_Branch=1 and ID_BranchTaken=1: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=1.
  - Otherwise: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- FSM states are RUN, STALL and HALT; reset state is RUN.
  - RUN -> STALL when Stall=1.
  - STALL -> RUN when Stall=0.
  - STALL -> HALT when the consecutive counter would reach MAX_STALL.
  - HALT is absorbing until Rst.
- Consecutive counter ConsecStall is 4 bits, reset 0. It increments on each edge with Stall=1 (outside HALT) and clears on each edge with Stall=0. The edge that makes it equal MAX_STALL enters HALT and sets Deadlock=1.
- Deadlock: reset 0, sticky until Rst.
- StallCycles: reset 0. It increments on each edge with Stall=1 outside HALT and saturates at all-ones, with no wrap.
- FlushCount: reset 0. It increments on each edge with IF_ID_Flush=1 and saturates at all-ones.
- Reset mid-stall: asserting Rst immediately forces the safe outputs and clears the state and all counters. Counting resumes on the first edge after Rst deasserts.

Decomposition:
- Shared package holds the state encoding (RUN=2'd0, STALL=2'd1, HALT=2'd2), the REG_ZERO=5'd0 constant and the RegWrite "none" encoding 2'b00. The forwarding logic uses the same constants.
- One sub-module, reg_dep_match, implements the match rule. It is instantiated twice (EX and MEM) and is reused by the forwarding logic.

Test Plan:
- Load-use: EX load to $8, ID_Rs=8, held 1 cycle -> Stall for exactly 1 cycle (PCWrite=0, ID_EX_Bubble=1). StallCycles=1, state returns to RUN.
- ALU op writing $9 in EX, ID branch with ID_Rt=9, ID_UsesRt=1 -> 1 stall cycle. The next cycle has no EX match and the branch is taken -> IF_ID_Flush=1 and FlushCount=1.
- Load to $10, then a dependent branch -> 2 stall cycles (LU as BRE, then BRM). IF_ID_Flush stays 0 during both, even with ID_BranchTaken=1. StallCycles=2.
- Destination $0 with EX_MemRead=1 and ID_Rs=0 -> no stall; PCWrite stays 1.
- Stall held continuously with MAX_STALL=4 -> HALT and Deadlock=1 on the 4th edge. PCWrite stays 0 after the stall clears; Rst restores RUN, Deadlock=0 and counters=0.
- CNT_W=4 with 20 stall-then-clear pairs -> StallCycles saturates at 15. Rst pulsed mid-stall clears it asynchronously, before the next clock edge.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the hazard/stall controller and the EX-stage
// forwarding logic.
//   hz_state_t : controller state encoding (RUN / STALL / HALT)
//   REG_ZERO   : architectural zero register, never a real dependency
//   RW_NONE    : register-write class meaning "no write"
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] RW_NONE  = 2'b00;

  // Width of the consecutive-stall counter; MAX_STALL must fit in it.
  localparam int CONSEC_W = 4;

endpackage

// File: rtl/hazard_stall_unit_reg_dep_match.sv
// Register dependency matcher: reports whether a producer's destination
// register is read by the instruction currently in ID.
//   addr    : destination register of the producing instruction
//   rs, rt  : source registers of the ID instruction
//   uses_rt : the ID instruction actually reads rt
//   hit     : dependency exists (writes to the zero register never count)
module reg_dep_match
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] addr,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hit
);

  assign hit = (addr != REG_ZERO) && ((addr == rs) || (uses_rt && (addr == rt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller. Detects hazards forwarding cannot cover
// (load-use, and branch-in-ID operand dependencies on EX/MEM results),
// freezes or squashes the front end, and tracks a consecutive-stall
// watchdog plus saturating performance counters.
//   Clk, Rst                : clock, asynchronous active-high reset
//   ID_*                    : source operands / branch info of the ID instruction
//   EX_*, MEM_*             : destination / class of instructions in EX and MEM
//   PCWrite, IF_ID_Write    : front-end write enables (low = freeze)
//   IF_ID_Flush             : squash IF/ID on a taken branch
//   ID_EX_Bubble            : inject a NOP into ID/EX
//   Deadlock                : sticky watchdog error, cleared only by Rst
//   StallCycles, FlushCount : saturating event counters
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4   // legal range 3..15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic [4:0]       EX_RegWriteAddress,
  input  logic [1:0]       EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_RegWriteAddress,
  input  logic             MEM_MemRead,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Deadlock,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CONSEC_W-1:0] MAX_CONSEC = CONSEC_W'(MAX_STALL);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

  // Dependency matchers: index 0 looks at EX, index 1 at MEM.
  logic [4:0] dep_addr [2];
  logic [1:0] dep_hit;

  assign dep_addr[0] = EX_RegWriteAddress;
  assign dep_addr[1] = MEM_RegWriteAddress;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      reg_dep_match u_match (
        .addr   (dep_addr[gi]),
        .rs     (ID_Rs),
        .rt     (ID_Rt),
        .uses_rt(ID_UsesRt),
        .hit    (dep_hit[gi])
      );
    end
  endgenerate

  logic load_use;
  logic branch_ex;
  logic branch_mem;
  logic stall;

  // A branch resolved in ID needs its operands one stage earlier than an
  // ALU consumer, so any pending EX write blocks it, and a load still in
  // MEM blocks it a second cycle.
  assign load_use   = EX_MemRead & dep_hit[0];
  assign branch_ex  = ID_Branch & (EX_RegWrite != RW_NONE) & dep_hit[0];
  assign branch_mem = ID_Branch & MEM_MemRead & dep_hit[1];
  assign stall      = load_use | branch_ex | branch_mem;

  hz_state_t            state_reg;
  logic [CONSEC_W-1:0]  consec_reg;
  logic [CONSEC_W-1:0]  consec_next;
  logic                 deadlock_reg;
  logic [CNT_W-1:0]     stall_cnt_reg;
  logic [CNT_W-1:0]     flush_cnt_reg;
  logic                 halted;

  assign halted      = (state_reg == ST_HALT);
  assign consec_next = consec_reg + CONSEC_W'(1);

  // Front-end controls. Reset is included so the safe values appear the
  // instant Rst rises, without waiting for a clock edge.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (Rst || halted || stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_Branch && ID_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  // Watchdog FSM: HALT is entered on the edge that brings the run of
  // back-to-back stall cycles up to MAX_STALL, and held until reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg    <= ST_RUN;
      consec_reg   <= '0;
      deadlock_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN, ST_STALL: begin
          if (stall) begin
            consec_reg <= consec_next;
            if (consec_next == MAX_CONSEC) begin
              state_reg    <= ST_HALT;
              deadlock_reg <= 1'b1;
            end else begin
              state_reg <= ST_STALL;
            end
          end else begin
            consec_reg <= '0;
            state_reg  <= ST_RUN;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating counters; a stall seen while halted is not a new stall.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && !halted && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (IF_ID_Flush && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign Deadlock    = deadlock_reg;
  assign StallCycles = stall_cnt_reg;
  assign FlushCount  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: a default-width instance and a 4-bit
// counter instance share all stimulus; a behavioural model tracks the
// expected controls, watchdog and (unbounded) event counts.
module tb_hazard_stall_unit;

  localparam int MAX_STALL = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_RegWriteAddress, MEM_RegWriteAddress;
  logic       ID_UsesRt, ID_Branch, ID_BranchTaken, EX_MemRead, MEM_MemRead;
  logic [1:0] EX_RegWrite;

  logic        pcw, ifw, flush, bubble, dead;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pcw4, ifw4, flush4, bubble4, dead4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  hazard_stall_unit #(.CNT_W(16), .MAX_STALL(MAX_STALL)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .EX_RegWriteAddress(EX_RegWriteAddress), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_RegWriteAddress(MEM_RegWriteAddress),
    .MEM_MemRead(MEM_MemRead), .PCWrite(pcw), .IF_ID_Write(ifw),
    .IF_ID_Flush(flush), .ID_EX_Bubble(bubble), .Deadlock(dead),
    .StallCycles(stall_cnt), .FlushCount(flush_cnt)
  );

  hazard_stall_unit #(.CNT_W(4), .MAX_STALL(MAX_STALL)) dut4 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .EX_RegWriteAddress(EX_RegWriteAddress), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_RegWriteAddress(MEM_RegWriteAddress),
    .MEM_MemRead(MEM_MemRead), .PCWrite(pcw4), .IF_ID_Write(ifw4),
    .IF_ID_Flush(flush4), .ID_EX_Bubble(bubble4), .Deadlock(dead4),
    .StallCycles(stall_cnt4), .FlushCount(flush_cnt4)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic [4:0] ex_rd;
    logic [1:0] ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       pcw;
    logic       ifw;
    logic       flush;
    logic       bub;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  // Model state: halted flag, current run of stall cycles, total events.
  bit m_halt;
  int m_consec;
  int m_stalls;
  int m_flushes;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit reads(logic [4:0] a);
    return (a != 5'd0) && ((a == ID_Rs) || (ID_UsesRt && (a == ID_Rt)));
  endfunction

  function automatic bit model_stall();
    bit lu, bre, brm;
    lu  = EX_MemRead && reads(EX_RegWriteAddress);
    bre = ID_Branch && (EX_RegWrite != 2'b00) && reads(EX_RegWriteAddress);
    brm = ID_Branch && MEM_MemRead && reads(MEM_RegWriteAddress);
    return lu || bre || brm;
  endfunction

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_consec = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Account for one rising edge with the current inputs.
  task automatic model_edge();
    if (!m_halt) begin
      if (model_stall()) begin
        m_stalls++;
        m_consec++;
        if (m_consec == MAX_STALL) m_halt = 1;
      end else begin
        m_consec = 0;
        if (ID_Branch && ID_BranchTaken) m_flushes++;
      end
    end
  endtask

  task automatic check_ports(string tag, bit e_pcw, bit e_ifw, bit e_fl, bit e_bub);
    check({tag, ".PCWrite"},      32'(pcw),     32'(e_pcw));
    check({tag, ".IF_ID_Write"},  32'(ifw),     32'(e_ifw));
    check({tag, ".IF_ID_Flush"},  32'(flush),   32'(e_fl));
    check({tag, ".ID_EX_Bubble"}, 32'(bubble),  32'(e_bub));
    check({tag, ".PCWrite4"},     32'(pcw4),    32'(e_pcw));
    check({tag, ".IF_ID_Flush4"}, 32'(flush4),  32'(e_fl));
    check({tag, ".IF_ID_Write4"}, 32'(ifw4),    32'(e_ifw));
    check({tag, ".ID_EX_Bubble4"},32'(bubble4), 32'(e_bub));
  endtask

  task automatic check_regs(string tag);
    check({tag, ".Deadlock"},     32'(dead),       32'(m_halt));
    check({tag, ".Deadlock4"},    32'(dead4),      32'(m_halt));
    check({tag, ".StallCycles"},  32'(stall_cnt),  32'(sat(m_stalls, 65535)));
    check({tag, ".FlushCount"},   32'(flush_cnt),  32'(sat(m_flushes, 65535)));
    check({tag, ".StallCycles4"}, 32'(stall_cnt4), 32'(sat(m_stalls, 15)));
    check({tag, ".FlushCount4"},  32'(flush_cnt4), 32'(sat(m_flushes, 15)));
  endtask

  task automatic check_model(string tag);
    if (Rst || m_halt || model_stall()) check_ports(tag, 0, 0, 0, 1);
    else if (ID_Branch && ID_BranchTaken) check_ports(tag, 1, 1, 1, 0);
    else check_ports(tag, 1, 1, 0, 0);
    check_regs(tag);
  endtask

  task automatic apply(vec_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt;
    ID_Branch = v.br; ID_BranchTaken = v.taken;
    EX_RegWriteAddress = v.ex_rd; EX_RegWrite = v.ex_rw; EX_MemRead = v.ex_mr;
    MEM_RegWriteAddress = v.mem_rd; MEM_MemRead = v.mem_mr;
  endtask

  task automatic idle();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 0; ID_Branch = 0; ID_BranchTaken = 0;
    EX_RegWriteAddress = 5'd0; EX_RegWrite = 2'b00; EX_MemRead = 0;
    MEM_RegWriteAddress = 5'd0; MEM_MemRead = 0;
  endtask

  task automatic load_use_8();
    idle();
    ID_Rs = 5'd8; EX_RegWriteAddress = 5'd8; EX_RegWrite = 2'b01; EX_MemRead = 1;
  endtask

  // Entered at posedge+1 with inputs already driven: check, then clock.
  task automatic step(string tag);
    #2;
    check_model(tag);
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  // Reset pulse between edges; checks the asynchronous clear.
  task automatic do_reset(string tag);
    Rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    Rst = 1'b0;
  endtask

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //              rs  rt ut br tk exrd rw mr memrd mm  pcw ifw fl bub
    tbl[0]  = '{5'd1, 5'd2, 0, 0, 0, 5'd0, 2'd0, 0, 5'd0, 0,  1, 1, 0, 0};
    tbl[1]  = '{5'd8, 5'd0, 0, 0, 0, 5'd8, 2'd1, 1, 5'd0, 0,  0, 0, 0, 1};
    tbl[2]  = '{5'd1, 5'd2, 0, 0, 0, 5'd3, 2'd1, 0, 5'd0, 0,  1, 1, 0, 0};
    tbl[3]  = '{5'd4, 5'd9, 1, 1, 1, 5'd9, 2'd1, 0, 5'd0, 0,  0, 0, 0, 1};
    tbl[4]  = '{5'd4, 5'd9, 1, 1, 1, 5'd0, 2'd0, 0, 5'd9, 0,  1, 1, 1, 0};
    tbl[5]  = '{5'd10,5'd0, 0, 1, 1, 5'd10,2'd1, 1, 5'd0, 0,  0, 0, 0, 1};
    tbl[6]  = '{5'd10,5'd0, 0, 1, 1, 5'd0, 2'd0, 0, 5'd10,1,  0, 0, 0, 1};
    tbl[7]  = '{5'd10,5'd0, 0, 1, 1, 5'd0, 2'd0, 0, 5'd10,0,  1, 1, 1, 0};
    tbl[8]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 2'd1, 1, 5'd0, 0,  1, 1, 0, 0};
    tbl[9]  = '{5'd3, 5'd5, 0, 0, 0, 5'd5, 2'd1, 1, 5'd0, 0,  1, 1, 0, 0};
    tbl[10] = '{5'd3, 5'd5, 1, 0, 0, 5'd5, 2'd1, 1, 5'd0, 0,  0, 0, 0, 1};
    tbl[11] = '{5'd7, 5'd0, 0, 0, 0, 5'd0, 2'd0, 0, 5'd7, 1,  1, 1, 0, 0};
    tbl[12] = '{5'd7, 5'd0, 0, 1, 0, 5'd7, 2'd0, 0, 5'd0, 0,  1, 1, 0, 0};
    tbl[13] = '{5'd6, 5'd6, 1, 1, 0, 5'd2, 2'd1, 0, 5'd0, 0,  1, 1, 0, 0};
    tbl[14] = '{5'd6, 5'd0, 0, 0, 1, 5'd6, 2'd2, 0, 5'd0, 0,  1, 1, 0, 0};
    tbl[15] = '{5'd2, 5'd9, 0, 1, 1, 5'd9, 2'd1, 0, 5'd0, 0,  1, 1, 1, 0};

    // Power-on reset held across edges; outputs must be safe throughout.
    Rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_model("reset");
    Rst = 1'b0;

    // Directed table: priority of the front-end controls.
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      #2;
      check_ports($sformatf("vec%0d", i), tbl[i].pcw, tbl[i].ifw, tbl[i].flush, tbl[i].bub);
      check_regs($sformatf("vec%0d", i));
      @(posedge Clk);
      model_edge();
      #1;
    end
    idle();
    #2;
    check("table.StallCycles", 32'(stall_cnt), 32'd5);
    check("table.FlushCount",  32'(flush_cnt), 32'd3);
    @(posedge Clk);
    #1;

    // Continuous stall: HALT on the MAX_STALL-th edge, then absorbing.
    do_reset("halt.rst");
    load_use_8();
    for (int i = 0; i < MAX_STALL; i++) step($sformatf("halt.hold%0d", i));
    check("halt.Deadlock", 32'(dead), 32'd1);
    check("halt.StallCycles", 32'(stall_cnt), 32'(MAX_STALL));
    step("halt.still_stalled");
    idle();
    ID_Branch = 1; ID_BranchTaken = 1;
    step("halt.cleared");
    step("halt.cleared2");
    check("halt.PCWrite_low", 32'(pcw), 32'd0);
    check("halt.FlushCount", 32'(flush_cnt), 32'd0);
    do_reset("halt.recover");
    step("halt.run_again");

    // Saturation of the 4-bit counter with 20 stall/clear pairs.
    do_reset("sat.rst");
    for (int i = 0; i < 20; i++) begin
      load_use_8();
      step("sat.stall");
      idle();
      step("sat.clear");
    end
    check("sat.StallCycles4", 32'(stall_cnt4), 32'd15);
    check("sat.StallCycles",  32'(stall_cnt),  32'd20);

    // Reset asserted mid-stall clears everything before the next edge.
    load_use_8();
    #2;
    Rst = 1'b1;
    #1;
    model_reset();
    check_model("midrst");
    check("midrst.StallCycles4", 32'(stall_cnt4), 32'd0);
    Rst = 1'b0;
    step("midrst.resume");
    check("midrst.first_count", 32'(stall_cnt), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset("rnd.rst");
      end
      ID_Rs = 5'($urandom_range(0, 7));
      ID_Rt = 5'($urandom_range(0, 7));
      ID_UsesRt = 1'($urandom);
      ID_Branch = 1'($urandom);
      ID_BranchTaken = 1'($urandom);
      EX_RegWriteAddress = 5'($urandom_range(0, 7));
      EX_RegWrite = 2'($urandom);
      EX_MemRead = ($urandom_range(0, 3) == 0);
      MEM_RegWriteAddress = 5'($urandom_range(0, 7));
      MEM_MemRead = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
